// File: rtl/rv_mem_bridge.sv
// Multicycle memory bridge: turns single-word core load/store requests into a
// req/ack bus transfer with alignment checking and a hung-bus timeout.
module rv_mem_bridge #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_core_req,
  input  logic          i_core_we,
  input  logic [AW-1:0] i_core_addr,
  input  logic [DW-1:0] i_core_wdata,
  output logic [DW-1:0] o_core_rdata,
  output logic          o_core_done,
  output logic          o_core_err,
  output logic          o_core_stall,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mem_ack
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ERR} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_core_rdata;
  logic          r_core_done;
  logic          r_core_err;
  logic          w_misalign;
  logic          w_limit;

  assign w_misalign = (i_core_addr[1:0] != 2'b00);
  assign w_limit    = (r_cnt == CW'(TIMEOUT - 1));

  // Stall is the only combinational output: the core waits until a result pulse.
  assign o_core_stall = i_core_req & ~r_core_done & ~r_core_err;

  assign o_core_rdata = r_core_rdata;
  assign o_core_done  = r_core_done;
  assign o_core_err   = r_core_err;
  assign o_mem_req    = r_mem_req;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;

  // Control FSM; result pulses default low so DONE/ERR last exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_rdata <= '0;
      r_core_done  <= 1'b0;
      r_core_err   <= 1'b0;
    end else begin
      r_core_done <= 1'b0;
      r_core_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_core_req) begin
            if (w_misalign) begin
              r_core_err <= 1'b1;
              r_state    <= S_ERR;
            end else begin
              r_mem_we    <= i_core_we;
              r_mem_addr  <= i_core_addr;
              r_mem_wdata <= i_core_wdata;
              r_cnt       <= '0;
              r_mem_req   <= 1'b1;
              r_state     <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // An ack on the final allowed cycle still counts as success.
          if (i_mem_ack) begin
            if (!r_mem_we) r_core_rdata <= i_mem_rdata;
            r_mem_req   <= 1'b0;
            r_core_done <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_limit) begin
            r_mem_req  <= 1'b0;
            r_core_err <= 1'b1;
            r_state    <= S_ERR;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
